// File: rtl/mp64_sram_req_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mp64_sram_req_ctrl : request front-end for the mp64_sram_sp line RAM.
// Define MP64_SRAM_RMW_EN to turn strobed partial writes into read-modify-write.
// Revision 1.0
// ----------------------------------------------------------------------------
module mp64_sram_req_ctrl #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 512,
  parameter int OUT_REG   = 0,
  parameter int RSP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata,
  output logic                  busy
);

  localparam int LAT    = 1 + OUT_REG;
  localparam int STRB_W = DATA_W / 8;
  localparam int CRD_W  = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CRD_W-1:0] DEPTH_C  = CRD_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_RMW_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [LAT-1:0]    tag_vld_q, tag_vld_d;
  logic [LAT-1:0]    tag_rsp_q, tag_rsp_d;
  logic [CRD_W-1:0]  credits_q, credits_d;
  logic [CRD_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] fifo_mem_q [RSP_DEPTH];

  logic              accept;
  logic              issue_rd;
  logic              issue_rsp;
  logic              fifo_push;
  logic              rsp_pop;
  logic              wr_full;
  logic              rmw_start;
  logic              rmw_wr;
  logic [ADDR_W-1:0] rmw_addr;
  logic [DATA_W-1:0] rmw_merged;

  // Credits cover FIFO entries plus response reads still inside the RAM pipe.
  assign req_ready = rst_n && (state_q == ST_IDLE) && (credits_q < DEPTH_C);
  assign accept    = req_valid && req_ready;
  assign issue_rd  = accept && !(req_we && wr_full);
  assign issue_rsp = accept && !req_we;
  assign fifo_push = tag_vld_q[LAT-1] && tag_rsp_q[LAT-1];
  assign rsp_valid = (fifo_cnt_q != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_data  = fifo_mem_q[rd_ptr_q];
  assign busy      = (state_q != ST_IDLE) || (|tag_vld_q) || (fifo_cnt_q != '0);

`ifdef MP64_SRAM_RMW_EN
  logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
  logic [DATA_W-1:0] rmw_wdata_q, rmw_wdata_d;
  logic [STRB_W-1:0] rmw_strb_q, rmw_strb_d;

  always_comb begin
    wr_full     = &req_wstrb;
    rmw_start   = accept && req_we && !wr_full;
    rmw_wr      = rst_n && (state_q == ST_RMW_WAIT) &&
                  tag_vld_q[LAT-1] && !tag_rsp_q[LAT-1];
    rmw_addr_d  = rmw_addr_q;
    rmw_wdata_d = rmw_wdata_q;
    rmw_strb_d  = rmw_strb_q;
    if (rmw_start) begin
      rmw_addr_d  = req_addr;
      rmw_wdata_d = req_wdata;
      rmw_strb_d  = req_wstrb;
    end
    rmw_addr   = rmw_addr_q;
    rmw_merged = sram_rdata;
    for (int i = 0; i < STRB_W; i++) begin
      if (rmw_strb_q[i]) rmw_merged[8*i +: 8] = rmw_wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    rmw_addr_q  <= rmw_addr_d;
    rmw_wdata_q <= rmw_wdata_d;
    rmw_strb_q  <= rmw_strb_d;
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^req_wstrb;

  always_comb begin
    wr_full    = 1'b1;
    rmw_start  = 1'b0;
    rmw_wr     = 1'b0;
    rmw_addr   = '0;
    rmw_merged = '0;
  end
`endif

  always_comb begin
    sram_ce    = accept || rmw_wr;
    sram_we    = rmw_wr || (accept && req_we && wr_full);
    sram_addr  = rmw_wr ? rmw_addr : req_addr;
    sram_wdata = rmw_wr ? rmw_merged : req_wdata;
  end

  generate
    if (LAT == 1) begin : g_tag_single
      assign tag_vld_d = issue_rd;
      assign tag_rsp_d = issue_rsp;
    end else begin : g_tag_shift
      assign tag_vld_d = {tag_vld_q[LAT-2:0], issue_rd};
      assign tag_rsp_d = {tag_rsp_q[LAT-2:0], issue_rsp};
    end
  endgenerate

  always_comb begin
    credits_d = credits_q;
    if (issue_rsp && !rsp_pop)      credits_d = credits_q + CRD_W'(1);
    else if (!issue_rsp && rsp_pop) credits_d = credits_q - CRD_W'(1);

    fifo_cnt_d = fifo_cnt_q;
    if (fifo_push && !rsp_pop)      fifo_cnt_d = fifo_cnt_q + CRD_W'(1);
    else if (!fifo_push && rsp_pop) fifo_cnt_d = fifo_cnt_q - CRD_W'(1);

    wr_ptr_d = wr_ptr_q;
    if (fifo_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    rd_ptr_d = rd_ptr_q;
    if (rsp_pop)   rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);

    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (rmw_start) state_d = ST_RMW_WAIT;
      ST_RMW_WAIT: if (rmw_wr)    state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Reset drops tags and FIFO contents, so in-flight reads and a pending RMW vanish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tag_vld_q  <= '0;
      tag_rsp_q  <= '0;
      credits_q  <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      tag_vld_q  <= tag_vld_d;
      tag_rsp_q  <= tag_rsp_d;
      credits_q  <= credits_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem_q[wr_ptr_q] <= sram_rdata;
  end

endmodule
`default_nettype wire
